time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Sequences user time-setting for the hh:mm:ss clock datapath. Two debounced buttons step
//  RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN and increment the field being edited.
//  Edits are made in a shadow copy and committed to the BCD time counter by a one-cycle load.
//  Also drives the counter run enable and the blink phase used by the display mux/scan.
// PARAMETERS
//  BLINK_TICKS    256   tick_en pulses per blink half-period (toggle of blink_on in SET states)
//  TIMEOUT_TICKS  4096  tick_en pulses with no button edge in a SET state before abort to RUN
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  tick_en     in   1  single-cycle enable from the frequency divider (blink/timeout timebase)
//  btn_mode    in   1  debounced level, synchronous to clk; rising edge = next state
//  btn_inc     in   1  debounced level, synchronous to clk; rising edge = increment field
//  cur_hr      in   8  current hours, packed BCD {tens,units}, from time counter
//  cur_min     in   8  current minutes, packed BCD
//  cur_sec     in   8  current seconds, packed BCD
//  run_en      out  1  1 = time counter may advance; 0 while any SET state is active
//  load        out  1  one-cycle pulse: counter loads ld_hr/ld_min/ld_sec
//  ld_hr       out  8  shadow hours, packed BCD (valid in SET states and when load=1)
//  ld_min      out  8  shadow minutes, packed BCD
//  ld_sec      out  8  shadow seconds, packed BCD
//  edit_field  out  2  0=none(RUN) 1=hours 2=minutes 3=seconds
//  blink_on    out  1  1 = edited field visible; always 1 in RUN
// BEHAVIOUR
//  Reset: state RUN, run_en=1, load=0, ld_*=8'h00, edit_field=0, blink_on=1, counters 0,
//   edge-detect history regs=1 (button held through reset gives no edge).
//  Edge detect: edge = btn & ~btn_q; edge at cycle n acts on registers visible at n+1.
//  States (registered outputs, all update on the edge cycle +1):
//   RUN     : mode edge -> SET_HR; shadow <= {cur_hr,cur_min,cur_sec}; run_en<=0.
//             inc edge ignored.
//   SET_HR  : inc edge -> hr+1 BCD; 23 -> 00. mode edge -> SET_MIN.
//   SET_MIN : inc edge -> min+1 BCD; 59 -> 00 (no carry into hours). mode edge -> SET_SEC.
//   SET_SEC : inc edge -> sec+1 BCD; 59 -> 00 (no carry). mode edge -> RUN with load=1
//             for exactly one cycle, ld_* holding the final shadow; run_en=1 same cycle.
//  BCD increment: units 9 -> 0 with tens+1; then compare against the field max for wrap;
//   outputs are always legal BCD.
//  Simultaneous mode+inc edges in one cycle: mode wins, inc discarded.
//  Blink: in SET states count tick_en; on BLINK_TICKS-th tick toggle blink_on and clear count.
//   Any state change or inc edge forces blink_on=1 and clears the blink count. In RUN, blink_on=1.
//  Timeout: in SET states count tick_en; cleared by any button edge; reaching TIMEOUT_TICKS
//   -> RUN with load=0 (edits discarded), run_en=1. Timeout and mode edge in the same cycle:
//   the mode edge wins.
//  Counters saturate-free: both are cleared on entry to RUN; widths = $clog2(param)+1.
//  Async reset mid-edit: returns to RUN with no load pulse; counter resumes from its own value.
//  cur_* are sampled only on the RUN->SET_HR transition; later changes are ignored.
// STRUCTURE
//  Shared package/header: state encodings (RUN=0,SET_HR=1,SET_MIN=2,SET_SEC=3),
//   BCD constants HR_MAX=8'h23, MS_MAX=8'h59, BCD_ZERO=8'h00, edit_field codes.
//  Sub-module: btn_edge (clk, rst_n, lvl -> pulse), instantiated for btn_mode and btn_inc.
//  Top: one FSM always block, one shadow/BCD-increment block, blink and timeout counters.
// TESTING
//  Reset with btn_mode held high -> no state change; run_en=1, edit_field=0, blink_on=1.
//  cur=12:34:56, mode edge -> edit_field=1, run_en=0, ld=12:34:56; inc x12 -> ld_hr=8'h00.
//  SET_MIN from 58, inc x2 -> 59 then 00, ld_hr unchanged; SET_SEC from 09, inc -> 8'h10.
//  Full cycle: 3 mode edges after edits -> load high exactly 1 cycle with ld=edited time,
//   run_en=1, edit_field=0.
//  Mode+inc same cycle in SET_HR -> SET_MIN, ld_hr unchanged.
//  Idle in SET_MIN for TIMEOUT_TICKS ticks -> RUN, load never asserted; blink_on toggles every
//   BLINK_TICKS ticks before timeout.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// Shared encodings and BCD helpers for the hh:mm:ss time-setting controller.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    localparam logic [7:0] HR_MAX   = 8'h23;
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [7:0] BCD_ZERO = 8'h00;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    // Units roll into tens first; anything past the field maximum wraps to zero.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] nxt;
        if (val[3:0] >= 4'd9) nxt = {val[7:4] + 4'd1, 4'd0};
        else                  nxt = {val[7:4], val[3:0] + 4'd1};
        if (nxt > max) nxt = BCD_ZERO;
        return nxt;
    endfunction

    function automatic logic [1:0] field_of(input state_t st);
        logic [1:0] f;
        case (st)
            ST_SET_HR:  f = FIELD_HR;
            ST_SET_MIN: f = FIELD_MIN;
            ST_SET_SEC: f = FIELD_SEC;
            default:    f = FIELD_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl,
    output logic pulse
);
    logic lvl_q;

    // History resets high so a button held through reset produces no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b1;
        else        lvl_q <= lvl;
    end

    assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: edits a shadow hh:mm:ss and commits it with a one-cycle load.
module time_set_ctrl #(
    parameter int BLINK_TICKS   = 256,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hr,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       run_en,
    output logic       load,
    output logic [7:0] ld_hr,
    output logic [7:0] ld_min,
    output logic [7:0] ld_sec,
    output logic [1:0] edit_field,
    output logic       blink_on
);
    import time_set_ctrl_pkg::*;

    localparam int BL_W = $clog2(BLINK_TICKS) + 1;
    localparam int TO_W = $clog2(TIMEOUT_TICKS) + 1;

    logic mode_edge, inc_edge;
    state_t state_q, state_d;
    logic load_d;
    logic timeout_hit;
    logic [BL_W-1:0] blink_cnt;
    logic [TO_W-1:0] to_cnt;

    btn_edge u_mode_edge (.clk(clk), .rst_n(rst_n), .lvl(btn_mode), .pulse(mode_edge));
    btn_edge u_inc_edge  (.clk(clk), .rst_n(rst_n), .lvl(btn_inc),  .pulse(inc_edge));

    // A button edge on the final tick restarts the idle window instead of aborting.
    assign timeout_hit = tick_en && !mode_edge && !inc_edge &&
                         (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        case (state_q)
            ST_RUN:     if (mode_edge) state_d = ST_SET_HR;
            ST_SET_HR:  if (mode_edge) state_d = ST_SET_MIN;
            ST_SET_MIN: if (mode_edge) state_d = ST_SET_SEC;
            ST_SET_SEC: if (mode_edge) begin
                state_d = ST_RUN;
                load_d  = 1'b1;
            end
            default:    state_d = ST_RUN;
        endcase
        if (state_q != ST_RUN && timeout_hit) state_d = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            load    <= 1'b0;
        end else begin
            state_q <= state_d;
            load    <= load_d;
        end
    end

    assign run_en     = (state_q == ST_RUN);
    assign edit_field = field_of(state_q);

    // Mode wins over a simultaneous increment, so inc only acts without a mode edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_hr  <= BCD_ZERO;
            ld_min <= BCD_ZERO;
            ld_sec <= BCD_ZERO;
        end else if (state_q == ST_RUN) begin
            if (mode_edge) begin
                ld_hr  <= cur_hr;
                ld_min <= cur_min;
                ld_sec <= cur_sec;
            end
        end else if (inc_edge && !mode_edge) begin
            case (state_q)
                ST_SET_HR:  ld_hr  <= bcd_inc(ld_hr, HR_MAX);
                ST_SET_MIN: ld_min <= bcd_inc(ld_min, MS_MAX);
                ST_SET_SEC: ld_sec <= bcd_inc(ld_sec, MS_MAX);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state_d == ST_RUN || state_d != state_q || inc_edge) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick_en) begin
            if (blink_cnt == BL_W'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     to_cnt <= '0;
        else if (state_d == ST_RUN || mode_edge || inc_edge) to_cnt <= '0;
        else if (tick_en)                               to_cnt <= to_cnt + 1'b1;
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: reset, field edits, commit, priority and timeout/blink.
module tb_time_set_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick_en;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hr, cur_min, cur_sec;
    logic       run_en, load, blink_on;
    logic [7:0] ld_hr, ld_min, ld_sec;
    logic [1:0] edit_field;

    int total;
    int bad;
    int load_seen;

    time_set_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
        .run_en(run_en), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
        .edit_field(edit_field), .blink_on(blink_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (load === 1'b1) load_seen++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step();
            btn_inc = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick_en = 1'b0; btn_mode = 1'b1; btn_inc = 1'b0;
        cur_hr = 8'h12; cur_min = 8'h34; cur_sec = 8'h56;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        total++; if (edit_field !== 2'd0) begin bad++; $display("FAIL reset_edit_field got=%0d want=0", edit_field); end
        total++; if (run_en !== 1'b1) begin bad++; $display("FAIL reset_run_en got=%b want=1", run_en); end
        total++; if (blink_on !== 1'b1) begin bad++; $display("FAIL reset_blink_on got=%b want=1", blink_on); end
        total++; if (load !== 1'b0 || ld_hr !== 8'h00 || ld_min !== 8'h00 || ld_sec !== 8'h00) begin
            bad++; $display("FAIL reset_ld got=%b %h:%h:%h want=0 00:00:00", load, ld_hr, ld_min, ld_sec);
        end
        btn_mode = 1'b0;
        step();
        press_inc(1);
        total++; if (edit_field !== 2'd0 || ld_hr !== 8'h00) begin
            bad++; $display("FAIL run_inc_ignored got=%0d/%h want=0/00", edit_field, ld_hr);
        end
    endtask

    task automatic test_edit_fields();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        total++; if (edit_field !== 2'd1 || run_en !== 1'b0) begin
            bad++; $display("FAIL enter_set got=%0d/%b want=1/0", edit_field, run_en);
        end
        cur_hr = 8'h99; cur_min = 8'h99; cur_sec = 8'h99;
        step();
        total++; if ({ld_hr, ld_min, ld_sec} !== 24'h123456) begin
            bad++; $display("FAIL shadow_capture got=%h:%h:%h want=12:34:56", ld_hr, ld_min, ld_sec);
        end
        press_inc(11);
        total++; if (ld_hr !== 8'h23) begin bad++; $display("FAIL hr_inc11 got=%h want=23", ld_hr); end
        press_inc(1);
        total++; if (ld_hr !== 8'h00) begin bad++; $display("FAIL hr_wrap got=%h want=00", ld_hr); end
        press_mode();
        total++; if (edit_field !== 2'd2) begin bad++; $display("FAIL to_set_min got=%0d want=2", edit_field); end
        press_inc(24);
        total++; if (ld_min !== 8'h58) begin bad++; $display("FAIL min_58 got=%h want=58", ld_min); end
        press_inc(1);
        total++; if (ld_min !== 8'h59) begin bad++; $display("FAIL min_59 got=%h want=59", ld_min); end
        press_inc(1);
        total++; if (ld_min !== 8'h00 || ld_hr !== 8'h00) begin
            bad++; $display("FAIL min_wrap got=%h hr=%h want=00 hr=00", ld_min, ld_hr);
        end
        press_mode();
        total++; if (edit_field !== 2'd3 || blink_on !== 1'b1) begin
            bad++; $display("FAIL to_set_sec got=%0d/%b want=3/1", edit_field, blink_on);
        end
        press_inc(13);
        total++; if (ld_sec !== 8'h09) begin bad++; $display("FAIL sec_09 got=%h want=09", ld_sec); end
        press_inc(1);
        total++; if (ld_sec !== 8'h10) begin bad++; $display("FAIL sec_units_carry got=%h want=10", ld_sec); end
    endtask

    task automatic test_full_cycle();
        total++; if (load_seen !== 0) begin bad++; $display("FAIL early_load got=%0d want=0", load_seen); end
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        total++; if (load !== 1'b1 || {ld_hr, ld_min, ld_sec} !== 24'h000010) begin
            bad++; $display("FAIL commit got=%b %h:%h:%h want=1 00:00:10", load, ld_hr, ld_min, ld_sec);
        end
        total++; if (run_en !== 1'b1 || edit_field !== 2'd0) begin
            bad++; $display("FAIL commit_state got=%b/%0d want=1/0", run_en, edit_field);
        end
        step();
        total++; if (load !== 1'b0) begin bad++; $display("FAIL load_one_cycle got=%b want=0", load); end
        repeat (3) step();
        total++; if (load_seen !== 1) begin bad++; $display("FAIL load_count got=%0d want=1", load_seen); end
    endtask

    task automatic test_simultaneous();
        cur_hr = 8'h07; cur_min = 8'h08; cur_sec = 8'h09;
        press_mode();
        total++; if (edit_field !== 2'd1 || ld_hr !== 8'h07) begin
            bad++; $display("FAIL sim_enter got=%0d/%h want=1/07", edit_field, ld_hr);
        end
        btn_mode = 1'b1; btn_inc = 1'b1;
        step();
        btn_mode = 1'b0; btn_inc = 1'b0;
        step();
        total++; if (edit_field !== 2'd2 || ld_hr !== 8'h07 || ld_min !== 8'h08) begin
            bad++; $display("FAIL mode_wins got=%0d %h:%h want=2 07:08", edit_field, ld_hr, ld_min);
        end
    endtask

    task automatic test_timeout_blink();
        tick_en = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            step();
            if (i == 255) begin
                total++; if (blink_on !== 1'b1) begin bad++; $display("FAIL blink_255 got=%b want=1", blink_on); end
            end
            if (i == 256) begin
                total++; if (blink_on !== 1'b0) begin bad++; $display("FAIL blink_256 got=%b want=0", blink_on); end
            end
            if (i == 512) begin
                total++; if (blink_on !== 1'b1) begin bad++; $display("FAIL blink_512 got=%b want=1", blink_on); end
            end
            if (i == 4095) begin
                total++; if (edit_field !== 2'd2 || run_en !== 1'b0) begin
                    bad++; $display("FAIL pre_timeout got=%0d/%b want=2/0", edit_field, run_en);
                end
            end
        end
        tick_en = 1'b0;
        total++; if (edit_field !== 2'd0 || run_en !== 1'b1 || blink_on !== 1'b1) begin
            bad++; $display("FAIL timeout got=%0d/%b/%b want=0/1/1", edit_field, run_en, blink_on);
        end
        repeat (2) step();
        total++; if (load_seen !== 1) begin bad++; $display("FAIL timeout_no_load got=%0d want=1", load_seen); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        load_seen = 0;
        test_reset();
        test_edit_fields();
        test_full_cycle();
        test_simultaneous();
        test_timeout_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
